bsg_transpose_row_gather: RTL

Upstream feeder for the 16x16 bit-matrix transpose stage. Accepts one width_p-bit row per valid/ready handshake and assembles els_p rows into one packed matrix. Presents the complete matrix on a valid/yumi interface whose data_o drives the transpose input directly. Lets a serial row stream, one row per cycle, be transposed as whole matrices without stalling between matrices.

---
 rtl/bsg_transpose_row_gather.sv | 107 ++++++++++
 1 files changed

// File: rtl/bsg_transpose_row_gather.sv
// ---------------------------------------------------------------------------
// bsg_transpose_row_gather
//
// This block feeds the 16x16 bit-matrix transpose stage. It collects a
// serial stream of rows into one packed matrix and then hands the complete
// matrix downstream.
//
// Rows arrive one per valid/ready handshake. After els_p rows have been
// accepted, the packed matrix is presented on a valid/yumi interface.
// data_o connects directly to the transpose input.
//
// Handshakes:
//   input  side : a row transfers on a rising edge where v_i & ready_o.
//                 The sender holds v_i/data_i stable until that edge.
//   output side : the matrix is taken on a rising edge where yumi_i is high.
//                 yumi_i may only be raised while v_o is high.
//                 ready_o depends combinationally on yumi_i, so a new row
//                 can land at row 0 in the same edge the old matrix leaves.
//
// Ports:
//   clk_i      clock, rising edge
//   reset_n_i  asynchronous active-low reset
//   v_i        input row valid
//   data_i     input row, width_p bits
//   ready_o    a row can be accepted this cycle
//   v_o        a complete matrix is available
//   data_o     packed matrix; row r at data_o[r*width_p +: width_p]
//   yumi_i     consumer takes the matrix this cycle
//   count_o    rows currently held (0..els_p)
// ---------------------------------------------------------------------------
module bsg_transpose_row_gather #(
  parameter int width_p = 16,
  parameter int els_p   = 16,
  localparam int count_width_lp = ($clog2(els_p + 1) > 1) ? $clog2(els_p + 1) : 1
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       v_i,
  input  logic [width_p-1:0]         data_i,
  output logic                       ready_o,
  output logic                       v_o,
  output logic [width_p*els_p-1:0]   data_o,
  input  logic                       yumi_i,
  output logic [count_width_lp-1:0]  count_o
);

  localparam logic [count_width_lp-1:0] last_row_lp = count_width_lp'(els_p - 1);
  localparam logic [count_width_lp-1:0] full_count_lp = count_width_lp'(els_p);

  logic [count_width_lp-1:0] r_cnt;
  logic                      r_full;
  logic [width_p*els_p-1:0]  r_matrix;

  logic w_accept;
  logic w_consume;
  logic w_last_row;

  // While reset is held, ready_o is forced low. Otherwise a held matrix
  // blocks new rows unless it is being taken this very cycle.
  assign ready_o    = reset_n_i & (~r_full | yumi_i);
  assign v_o        = r_full;
  assign data_o     = r_matrix;
  assign count_o    = r_full ? full_count_lp : r_cnt;

  assign w_accept   = v_i & ready_o;
  assign w_consume  = yumi_i & r_full;
  assign w_last_row = (r_cnt == last_row_lp);

  // Row pointer and full flag.
  // While full, r_cnt is already back at 0, so an accept that coincides with
  // a consume uses the same path as a normal accept:
  //   - the row lands at row 0;
  //   - full stays set only if that row also completes a matrix (els_p == 1).
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_cnt  <= '0;
      r_full <= 1'b0;
    end else if (w_accept) begin
      r_full <= w_last_row;
      r_cnt  <= w_last_row ? '0 : r_cnt + 1'b1;
    end else if (w_consume) begin
      r_full <= 1'b0;
    end
  end

  // Row storage.
  // Rows not written since the last matrix keep stale data. Consumers only
  // look at data_o while v_o is high, so stale rows are never seen as valid.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_matrix <= '0;
    end else begin
      for (int r = 0; r < els_p; r++) begin
        if (w_accept && (r_cnt == count_width_lp'(r))) begin
          r_matrix[r*width_p +: width_p] <= data_i;
        end
      end
    end
  end

  // Protocol and configuration checks.
  a_yumi_needs_valid : assert property (@(posedge clk_i) disable iff (!reset_n_i)
    yumi_i |-> r_full);
  a_els_positive     : assert property (@(posedge clk_i) els_p >= 1);
  a_width_positive   : assert property (@(posedge clk_i) width_p >= 1);

endmodule
